// File: rtl/decode_pkg.sv
// Shared decode definitions for the D-stage hazard unit.
// Holds the MIPS field constants, the Tuse/Tnew encodings and the packed control record.
package decode_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a, FN_SLTU = 6'h2b, FN_ERET = 6'h18;

    localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04, RS_CO = 5'h10;
    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;

    // Tuse: cycles until D needs the operand; TUSE_NONE never triggers a stall
    localparam logic [1:0] TUSE_0 = 2'd0, TUSE_1 = 2'd1, TUSE_2 = 2'd2, TUSE_NONE = 2'd3;
    // Tnew: cycles until the result becomes forwardable, counted from E entry
    localparam logic [1:0] TNEW_0 = 2'd0, TNEW_1 = 2'd1, TNEW_2 = 2'd2;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;
    typedef enum logic       {EXT_ZERO, EXT_SIGN} ext_op_e;
    typedef enum logic [2:0] {LS_NONE, LS_B, LS_BU, LS_H, LS_HU, LS_W} ls_sel_e;
    typedef enum logic [2:0] {NPC_PC4, NPC_BR, NPC_J, NPC_JR, NPC_EPC} npc_sel_e;
    typedef enum logic [1:0] {RD_ALU, RD_MEM, RD_PC8, RD_CP0} reg_data_e;

    typedef struct packed {
        logic      regwr;
        logic      alusrc;
        alu_op_e   alu_op;
        ext_op_e   ext_op;
        ls_sel_e   ls_sel;
        npc_sel_e  npc_sel;
        reg_data_e reg_data;
        logic      shiftv;
        logic      dmwr;
        logic      cp0wr;
        logic      cp0rd;
        logic      eret;
        logic      ovf;
        logic      ri;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic alu_op_e fn_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB, FN_SUBU:   return ALU_SUB;
            FN_AND:            return ALU_AND;
            FN_OR:             return ALU_OR;
            FN_XOR:            return ALU_XOR;
            FN_NOR:            return ALU_NOR;
            FN_SLT:            return ALU_SLT;
            FN_SLTU:           return ALU_SLTU;
            FN_SLL, FN_SLLV:   return ALU_SLL;
            FN_SRL, FN_SRLV:   return ALU_SRL;
            FN_SRA, FN_SRAV:   return ALU_SRA;
            default:           return ALU_ADD;
        endcase
    endfunction

    function automatic alu_op_e op_alu(input logic [5:0] op);
        case (op)
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

    function automatic ls_sel_e ls_of(input logic [5:0] op);
        case (op)
            OP_LB, OP_SB: return LS_B;
            OP_LBU:       return LS_BU;
            OP_LH, OP_SH: return LS_H;
            OP_LHU:       return LS_HU;
            OP_LW, OP_SW: return LS_W;
            default:      return LS_NONE;
        endcase
    endfunction

    // Tnew ticks down once per advance and never wraps below zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == TNEW_0) ? TNEW_0 : (t - 2'd1);
    endfunction

endpackage

// File: rtl/decode_hazard_unit_instr_decode.sv
// Purely combinational MIPS decoder: control record, destination, Tnew and Tuse per operand.
module instr_decode
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic [4:0]  o_dst,
    output logic [1:0]  o_tnew,
    output logic [1:0]  o_tuse_rs,
    output logic [1:0]  o_tuse_rt,
    output logic        o_legal
);
    logic [5:0] w_op, w_fn;
    logic [4:0] w_rs, w_rt, w_rd;
    ctrl_t      w_ctrl;
    logic [4:0] w_dst;
    logic [1:0] w_tnew, w_tuse_rs, w_tuse_rt;
    logic       w_legal;

    assign w_op = i_instr[31:26];
    assign w_rs = i_instr[25:21];
    assign w_rt = i_instr[20:16];
    assign w_rd = i_instr[15:11];
    assign w_fn = i_instr[5:0];

    // Field decode of the supported integer ISA
    always_comb begin
        w_ctrl    = ctrl_t'('0);
        w_dst     = 5'd0;
        w_tnew    = TNEW_0;
        w_tuse_rs = TUSE_NONE;
        w_tuse_rt = TUSE_NONE;
        w_legal   = 1'b1;
        case (w_op)
            OP_SPECIAL: begin
                case (w_fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        w_ctrl.regwr  = 1'b1;
                        w_ctrl.alu_op = fn_alu(w_fn);
                        w_ctrl.shiftv = (w_fn[5:2] == 4'b0001);
                        w_ctrl.ovf    = (w_fn == FN_ADD) || (w_fn == FN_SUB);
                        w_dst         = w_rd;
                        w_tnew        = TNEW_1;
                        w_tuse_rt     = TUSE_1;
                        // fixed-amount shifts take shamt, not rs
                        w_tuse_rs     = (w_fn[5:2] == 4'b0000) ? TUSE_NONE : TUSE_1;
                    end
                    FN_JR: begin
                        w_ctrl.npc_sel = NPC_JR;
                        w_tuse_rs      = TUSE_0;
                    end
                    FN_JALR: begin
                        w_ctrl.regwr    = 1'b1;
                        w_ctrl.npc_sel  = NPC_JR;
                        w_ctrl.reg_data = RD_PC8;
                        w_dst           = w_rd;
                        w_tuse_rs       = TUSE_0;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                if ((w_rt == RT_BLTZ) || (w_rt == RT_BGEZ)) begin
                    w_ctrl.npc_sel = NPC_BR;
                    w_tuse_rs      = TUSE_0;
                end else begin
                    w_legal = 1'b0;
                end
            end
            OP_J: w_ctrl.npc_sel = NPC_J;
            OP_JAL: begin
                w_ctrl.regwr    = 1'b1;
                w_ctrl.npc_sel  = NPC_J;
                w_ctrl.reg_data = RD_PC8;
                w_dst           = 5'd31;
            end
            OP_BEQ, OP_BNE: begin
                w_ctrl.npc_sel = NPC_BR;
                w_ctrl.ext_op  = EXT_SIGN;
                w_tuse_rs      = TUSE_0;
                w_tuse_rt      = TUSE_0;
            end
            OP_BLEZ, OP_BGTZ: begin
                w_ctrl.npc_sel = NPC_BR;
                w_ctrl.ext_op  = EXT_SIGN;
                w_tuse_rs      = TUSE_0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_ctrl.regwr  = 1'b1;
                w_ctrl.alusrc = 1'b1;
                w_ctrl.alu_op = op_alu(w_op);
                w_ctrl.ext_op = (w_op[5:2] == 4'b0011) ? EXT_ZERO : EXT_SIGN;
                w_ctrl.ovf    = (w_op == OP_ADDI);
                w_dst         = w_rt;
                w_tnew        = TNEW_1;
                w_tuse_rs     = (w_op == OP_LUI) ? TUSE_NONE : TUSE_1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                w_ctrl.regwr    = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.ext_op   = EXT_SIGN;
                w_ctrl.ls_sel   = ls_of(w_op);
                w_ctrl.reg_data = RD_MEM;
                w_dst           = w_rt;
                w_tnew          = TNEW_2;
                w_tuse_rs       = TUSE_1;
            end
            OP_SB, OP_SH, OP_SW: begin
                w_ctrl.alusrc = 1'b1;
                w_ctrl.ext_op = EXT_SIGN;
                w_ctrl.ls_sel = ls_of(w_op);
                w_ctrl.dmwr   = 1'b1;
                w_tuse_rs     = TUSE_1;
                w_tuse_rt     = TUSE_2;
            end
            OP_COP0: begin
                case (w_rs)
                    RS_MF: begin
                        w_ctrl.regwr    = 1'b1;
                        w_ctrl.cp0rd    = 1'b1;
                        w_ctrl.reg_data = RD_CP0;
                        w_dst           = w_rt;
                        w_tnew          = TNEW_2;
                    end
                    RS_MT: begin
                        w_ctrl.cp0wr = 1'b1;
                        w_tuse_rt    = TUSE_2;
                    end
                    RS_CO: begin
                        if (w_fn == FN_ERET) begin
                            w_ctrl.eret    = 1'b1;
                            w_ctrl.npc_sel = NPC_EPC;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Unsupported encodings become a no-write bubble that only carries the ri flag
    always_comb begin
        if (w_legal) begin
            o_ctrl    = w_ctrl;
            o_dst     = w_dst;
            o_tnew    = w_tnew;
            o_tuse_rs = w_tuse_rs;
            o_tuse_rt = w_tuse_rt;
        end else begin
            o_ctrl    = ctrl_t'('0);
            o_ctrl.ri = 1'b1;
            o_dst     = 5'd0;
            o_tnew    = TNEW_0;
            o_tuse_rs = TUSE_NONE;
            o_tuse_rt = TUSE_NONE;
        end
        o_legal = w_legal;
    end

endmodule

// File: rtl/decode_hazard_unit.sv
// D-stage decode with an E..W in-flight scoreboard producing stall and forward selects.
module decode_hazard_unit
    import decode_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int NREG   = 32,
    parameter int RA_W   = $clog2(NREG),
    parameter int SW     = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_d,
    input  logic              valid_d,
    input  logic              stall_ext,
    input  logic              flush,
    output logic              stall_d,
    output logic [SW-1:0]     fwd_rs_d,
    output logic [SW-1:0]     fwd_rt_d,
    output logic              illegal_d,
    output logic              e_valid,
    output logic [RA_W-1:0]   e_dst,
    output logic [CTRL_W-1:0] e_ctrl
);
    // stage k of the scoreboard: 1 = E ... STAGES = W
    logic [STAGES:1]           r_valid;
    logic [STAGES:1][RA_W-1:0] r_dst;
    logic [STAGES:1][1:0]      r_tnew;
    ctrl_t                     r_e_ctrl;

    ctrl_t           w_dec_ctrl;
    logic [4:0]      w_dec_dst;
    logic [1:0]      w_dec_tnew, w_dec_tuse_rs, w_dec_tuse_rt;
    logic            w_dec_legal;
    logic [RA_W-1:0] w_rs, w_rt, w_dst_d;
    logic            w_hit_rs, w_hit_rt;
    logic [SW-1:0]   w_fwd_rs, w_fwd_rt;

    instr_decode u_decode (
        .i_instr   (instr_d),
        .o_ctrl    (w_dec_ctrl),
        .o_dst     (w_dec_dst),
        .o_tnew    (w_dec_tnew),
        .o_tuse_rs (w_dec_tuse_rs),
        .o_tuse_rt (w_dec_tuse_rt),
        .o_legal   (w_dec_legal)
    );

    assign w_rs    = RA_W'(instr_d[25:21]);
    assign w_rt    = RA_W'(instr_d[20:16]);
    assign w_dst_d = RA_W'(w_dec_dst);

    // Scan youngest-last so the smallest matching stage wins the forward select
    always_comb begin
        w_hit_rs = 1'b0;
        w_hit_rt = 1'b0;
        w_fwd_rs = '0;
        w_fwd_rt = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (r_valid[k] && (r_dst[k] != '0) && (r_dst[k] == w_rs)) begin
                w_fwd_rs = SW'(k);
                w_hit_rs = w_hit_rs | (r_tnew[k] > w_dec_tuse_rs);
            end else begin
                w_fwd_rs = w_fwd_rs;
            end
            if (r_valid[k] && (r_dst[k] != '0) && (r_dst[k] == w_rt)) begin
                w_fwd_rt = SW'(k);
                w_hit_rt = w_hit_rt | (r_tnew[k] > w_dec_tuse_rt);
            end else begin
                w_fwd_rt = w_fwd_rt;
            end
        end
    end

    assign stall_d   = valid_d & (w_hit_rs | w_hit_rt);
    assign fwd_rs_d  = w_fwd_rs;
    assign fwd_rt_d  = w_fwd_rt;
    assign illegal_d = valid_d & ~w_dec_legal;

    // Scoreboard advance with priority flush > external freeze > hazard bubble > normal
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= '0;
            r_dst    <= '0;
            r_tnew   <= '0;
            r_e_ctrl <= ctrl_t'('0);
        end else if (flush) begin
            r_valid  <= '0;
            r_dst    <= '0;
            r_tnew   <= '0;
            r_e_ctrl <= ctrl_t'('0);
        end else if (stall_ext) begin
            r_valid  <= r_valid;
            r_dst    <= r_dst;
            r_tnew   <= r_tnew;
            r_e_ctrl <= r_e_ctrl;
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_dst[k]   <= r_dst[k-1];
                r_tnew[k]  <= tnew_dec(r_tnew[k-1]);
            end
            if (stall_d) begin
                r_valid[1] <= 1'b0;
                r_dst[1]   <= '0;
                r_tnew[1]  <= TNEW_0;
                r_e_ctrl   <= ctrl_t'('0);
            end else begin
                r_valid[1] <= valid_d;
                r_dst[1]   <= valid_d ? w_dst_d : '0;
                r_tnew[1]  <= valid_d ? w_dec_tnew : TNEW_0;
                r_e_ctrl   <= valid_d ? w_dec_ctrl : ctrl_t'('0);
            end
        end
    end

    assign e_valid = r_valid[1];
    assign e_dst   = r_dst[1];
    assign e_ctrl  = r_e_ctrl;

endmodule
